// File: rtl/pipe_skid_reg.sv
// DEPTH chained elastic stages (main + skid register each); one edge of latency per stage.
// Upstream ready is registered (~skid_valid of stage 0); synchronous flush clears all valids.
module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [WIDTH-1:0]               data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [WIDTH-1:0]               data_o,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy_o
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0]            m_v;
  logic [DEPTH-1:0]            s_v;
  logic [DEPTH-1:0]            up_valid;
  logic [DEPTH-1:0]            dn_ready;
  logic [DEPTH-1:0][WIDTH-1:0] m_d;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             mv_q;
    logic             sv_q;
    logic [WIDTH-1:0] md_q;
    logic [WIDTH-1:0] sd_q;
    logic             dn_fire;

    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid_i;
      assign up_data[k]  = data_i;
    end else begin : g_link
      assign up_valid[k] = m_v[k-1];
      assign up_data[k]  = m_d[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign dn_ready[k] = out_ready_i;
    end else begin : g_mid
      assign dn_ready[k] = ~s_v[k+1];
    end

    assign dn_fire = mv_q & dn_ready[k];

    // Skid only fills while main is stuck, so ready can lag by one edge without loss.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        mv_q <= 1'b0;
        sv_q <= 1'b0;
        md_q <= '0;
        sd_q <= '0;
      end else if (flush_i) begin
        mv_q <= 1'b0;
        sv_q <= 1'b0;
      end else if (sv_q) begin
        if (dn_fire) begin
          md_q <= sd_q;
          sv_q <= 1'b0;
        end
      end else if (!mv_q || dn_fire) begin
        mv_q <= up_valid[k];
        if (up_valid[k]) md_q <= up_data[k];
      end else if (up_valid[k]) begin
        sd_q <= up_data[k];
        sv_q <= 1'b1;
      end
    end

    assign m_v[k] = mv_q;
    assign s_v[k] = sv_q;
    assign m_d[k] = md_q;
  end

  assign in_ready_o  = ~s_v[0];
  assign out_valid_o = m_v[DEPTH-1];
  assign data_o      = m_d[DEPTH-1];

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy_o = occupancy_o + OCC_W'(m_v[i]) + OCC_W'(s_v[i]);
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the plain stall-gated pipeline register: a chain of DEPTH elastic stages with a valid/ready handshake on both sides.
- Each stage has a main register and a skid register, so upstream ready is fully registered.
- Adds a synchronous flush for branch/exception squashing and an occupancy count.
- Sits between CPU pipeline stages (IF/ID, ID/EX, ...) where back-pressure replaces the global stall wire.

Parameters:
WIDTH, 32, payload width in bits (>=1)
DEPTH, 1, number of chained elastic stages (1..8)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
flush_i  input  1  synchronous squash of all held entries
in_valid_i  input  1  upstream offers data_i
in_ready_o  output  1  stage 0 can accept; registered (= ~skid_valid of stage 0)
data_i  input  WIDTH  upstream payload
out_valid_o  output  1  main_valid of last stage
out_ready_i  input  1  downstream accepts; low = stall
data_o  output  WIDTH  main_data of last stage
occupancy_o  output  $clog2(2*DEPTH+1)  count of valid entries (main+skid, all stages), combinational from registered valids

Behaviour:
- Reset (rst_i=1, asynchronous): all main_valid/skid_valid=0, all data regs=0. Outputs: out_valid_o=0, data_o=0, in_ready_o=1, occupancy_o=0. Reset mid-transfer discards all entries.
- Per-stage state: m_v, m_d, s_v, s_d.
  - up_ready = ~s_v.
  - Down side presents m_v/m_d.
  - Stage k's up side is stage k-1's down side; stage 0's up side is in_*; stage DEPTH-1's down side is out_*.
- Transfer occurs when valid & ready are both high at the rising edge.
- Per-stage update (flush_i=0), with dn_fire = m_v & dn_ready:
  - s_v=1: if dn_fire then m_d<=s_d, m_v<=1, s_v<=0; upstream cannot fire.
  - s_v=0 and (m_v=0 or dn_fire): m_v<=up_valid; m_d<=up_data when up_valid.
  - s_v=0, m_v=1, no dn_fire: if up_valid then s_d<=up_data, s_v<=1 (skid capture); else hold.
- Ordering is strictly FIFO; no beat is duplicated or dropped absent flush.
- Latency: empty pipe, a beat accepted at edge N is on data_o with out_valid_o=1 after edge N+DEPTH-1, i.e. visible in cycle N+DEPTH.
- Throughput: 1 beat/cycle sustained when out_ready_i=1.
- Capacity: 2*DEPTH beats. With out_ready_i=0, in_ready_o falls the cycle after stage 0's skid fills.
- in_ready_o never depends combinationally on out_ready_i.
- Flush: at an edge with flush_i=1, all m_v and s_v clear to 0.
  - Data regs hold; their contents are don't-care.
  - Any in beat or out handshake in that cycle is discarded/ignored: no transfer is counted.
  - Next cycle: out_valid_o=0, in_ready_o=1, occupancy_o=0.
- Flush takes priority over all handshakes. Reset takes priority over flush.
- Data regs change only on capture, so no X propagation from unused data.
- occupancy_o = popcount of all m_v and s_v; range 0..2*DEPTH.

Test Plan:
- Reset/idle: assert rst_i asynchronously mid-cycle -> out_valid_o=0, data_o=0, in_ready_o=1, occupancy_o=0 immediately, before any clock edge.
- Streaming, DEPTH=3, WIDTH=32, out_ready_i=1: feed 0x11,0x22,0x33 on consecutive cycles -> 0x11 appears 3 cycles after its accept edge, then 0x22, 0x33 back-to-back; occupancy_o peaks at 3.
- Back-pressure, DEPTH=2, out_ready_i=0: push 0xA0..0xA5 -> exactly 4 accepted (0xA0..0xA3); in_ready_o=0, occupancy_o=4; raise out_ready_i -> 0xA0,0xA1,0xA2,0xA3 in order, 1/cycle, then 0xA4,0xA5 once re-accepted; no loss or duplicates.
- Skid toggle: random out_ready_i (50%) with an incrementing 16-bit stream of 1000 beats, DEPTH=1 -> output sequence equals input sequence; scoreboard checks in_ready_o is a pure register output.
- Flush: DEPTH=2, 3 beats held, assert flush_i one cycle while in_valid_i=1 with 0x77 -> next cycle occupancy_o=0, out_valid_o=0; 0x77 never emerges; a subsequent 0x88 emerges normally.
- Reset priority: rst_i and flush_i high together with a full pipe -> all-zero outputs. After release, first accepted beat 0x5 emerges with nominal latency.
